// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-N stream demultiplexer.
// The first beat of a packet picks the output channel. Later beats of that
// packet follow it there until the last beat. Beats sent to a channel number
// that does not exist are swallowed and counted in a saturating counter.
// Every output channel has its own one-entry register.
//
// Handshake: a beat moves on a port in every cycle where valid and ready are
// both 1 at the rising clock edge. A valid beat stays stable until it is
// taken. in_ready never depends on in_valid. out_valid never depends on
// out_ready.
`timescale 1ns/1ps
module stream_demux_n #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 8,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_last,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_last,
  output logic [15:0]            drop_count,
  output logic [1:0]             state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  // N_OUT is widened by one bit so that in_sel can be compared with it
  // even when N_OUT is a power of two.
  localparam logic [SEL_W:0] N_OUT_EXT = (SEL_W+1)'(N_OUT);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [SEL_W-1:0] chan_q;
  logic [SEL_W-1:0] tgt;
  logic             sel_ok;
  logic             drop_now;
  logic             acc;
  logic             tgt_free;
  logic [N_OUT-1:0] tgt_oh;
  logic [N_OUT-1:0] load;

  assign state_dbg = state_q;

  assign sel_ok   = ({1'b0, in_sel} < N_OUT_EXT);
  assign tgt      = (state_q == S_FWD) ? chan_q : in_sel;
  assign drop_now = (state_q == S_DROP) || ((state_q == S_IDLE) && !sel_ok);

  // One-hot decode of the target channel. An out-of-range select decodes to
  // all zeros.
  always_comb begin
    tgt_oh = '0;
    for (int k = 0; k < N_OUT; k++) begin
      tgt_oh[k] = (tgt == SEL_W'(k));
    end
  end

  // The target can take a beat when its register is empty or is being
  // drained in the same cycle.
  assign tgt_free = |(tgt_oh & (~out_valid | out_ready));
  assign in_ready = drop_now | tgt_free;
  assign acc      = in_valid & in_ready;
  assign load     = (acc && !drop_now) ? tgt_oh : '0;

  // Packet-lock FSM: the next state depends only on accepted beats.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (acc && !in_last) state_d = sel_ok ? S_FWD : S_DROP;
      end
      S_FWD, S_DROP: begin
        if (acc && in_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and locked channel registers. The channel is captured only on
  // the opening beat of a multi-beat packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && acc && sel_ok && !in_last) chan_q <= in_sel;
    end
  end

  // Per-channel output registers. A load has priority over a drain, so a
  // full register can be replaced in the same cycle it is drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_last  <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (load[k]) begin
          out_valid[k]                <= 1'b1;
          out_last[k]                 <= in_last;
          out_data[k*WIDTH +: WIDTH]  <= in_data;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Saturating count of discarded beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (acc && drop_now && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

endmodule
